// File: rtl/pixel_packer.sv
// Packs PIX_PER_WORD narrow pixels into one frame-buffer word and caps each frame at 2^ADDR_WIDTH words.
// Optional feature: define PARTIAL_FLUSH_EN to pad and write a partial word on eof.
module pixel_packer #(
    parameter int unsigned          PIX_WIDTH  = 8,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 3,
    parameter logic [PIX_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [PIX_WIDTH-1:0]  pix_data,
    input  logic                  sof,
    input  logic                  eof,
    output logic                  wr_en_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    localparam int unsigned PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
    localparam int unsigned LANE_W       = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int unsigned CNT_W        = ADDR_WIDTH + 1;
    localparam int unsigned CAP_WORDS    = 1 << ADDR_WIDTH;

`ifdef PARTIAL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                state;
    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-1:0] shreg;

    logic                  accept_c;
    logic                  word_done_c;
    logic                  write_c;
    logic                  cap_hit_c;
    logic [LANE_W-1:0]     eff_lane_c;
    logic [CNT_W-1:0]      base_cnt_c;
    logic [CNT_W-1:0]      next_cnt_c;
    logic [DATA_WIDTH-1:0] assembled_c;

    // A sof pixel always lands in lane 0 of a fresh word; lanes above the new pixel read as padding.
    always_comb begin
        eff_lane_c  = (sof || (state == IDLE)) ? '0 : lane;
        base_cnt_c  = sof ? '0 : word_cnt;
        accept_c    = pix_valid && (sof || (state == PACK));
        word_done_c = (eff_lane_c == LANE_W'(PIX_PER_WORD - 1));
        write_c     = accept_c && (word_done_c || (eof && FLUSH_EN));
        next_cnt_c  = base_cnt_c + CNT_W'(write_c);
        cap_hit_c   = write_c && (next_cnt_c == CNT_W'(CAP_WORDS));
        assembled_c = '0;
        for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
            if (i < 32'(eff_lane_c))
                assembled_c[i*PIX_WIDTH +: PIX_WIDTH] = shreg[i*PIX_WIDTH +: PIX_WIDTH];
            else if (i == 32'(eff_lane_c))
                assembled_c[i*PIX_WIDTH +: PIX_WIDTH] = pix_data;
            else
                assembled_c[i*PIX_WIDTH +: PIX_WIDTH] = PAD_VALUE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lane       <= '0;
            shreg      <= '0;
            data_out   <= '0;
            wr_en_out  <= 1'b1;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            wr_en_out  <= 1'b1;
            frame_done <= 1'b0;
            if (accept_c) begin
                shreg    <= assembled_c;
                word_cnt <= next_cnt_c;
                if (sof)
                    overflow <= 1'b0;
                if (write_c) begin
                    data_out  <= assembled_c;
                    wr_en_out <= 1'b0;
                end
                if (eof) begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    lane       <= '0;
                end else if (cap_hit_c) begin
                    frame_done <= 1'b1;
                    state      <= FULL;
                    lane       <= '0;
                end else begin
                    state <= PACK;
                    lane  <= word_done_c ? '0 : eff_lane_c + LANE_W'(1);
                end
            end else if (pix_valid && (state == FULL)) begin
                // Buffer is full: drop pixels until the frame ends or restarts.
                if (eof)
                    state <= IDLE;
                else
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_packer.sv
// Randomised and directed bench for pixel_packer, checked against a queue-based frame model.
module tb_pixel_packer;

    localparam int unsigned PIX_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned PPW        = DATA_WIDTH / PIX_WIDTH;
    localparam int unsigned CAP        = 1 << ADDR_WIDTH;
    localparam logic [PIX_WIDTH-1:0] PAD = 8'h00;

`ifdef PARTIAL_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pix_valid;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic                  sof;
    logic                  eof;
    logic                  wr_en_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_done;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   word_cnt;

    pixel_packer #(
        .PIX_WIDTH (PIX_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .PAD_VALUE (PAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .sof       (sof),
        .eof       (eof),
        .wr_en_out (wr_en_out),
        .data_out  (data_out),
        .frame_done(frame_done),
        .overflow  (overflow),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Frame model: pixels of the word in progress, words written, and frame status flags.
    logic [PIX_WIDTH-1:0]  cur_q[$];
    bit                    m_active;
    bit                    m_full;
    bit                    m_ovf;
    int                    m_cnt;
    logic [DATA_WIDTH-1:0] m_data;
    bit                    e_wr;
    bit                    e_fd;

    int wr_seen;
    int fd_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        m_active = 1'b0;
        m_full   = 1'b0;
        m_ovf    = 1'b0;
        m_cnt    = 0;
        m_data   = '0;
        e_wr     = 1'b1;
        e_fd     = 1'b0;
    endtask

    task automatic model_step(input bit pv, input logic [PIX_WIDTH-1:0] px, input bit s, input bit e);
        bit emit;
        e_wr = 1'b1;
        e_fd = 1'b0;
        emit = 1'b0;
        if (pv) begin
            if (s) begin
                cur_q.delete();
                m_cnt    = 0;
                m_ovf    = 1'b0;
                m_active = 1'b1;
                m_full   = 1'b0;
            end
            if (m_full) begin
                if (e) begin
                    m_full   = 1'b0;
                    m_active = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_active) begin
                cur_q.push_back(px);
                if (cur_q.size() == PPW)
                    emit = 1'b1;
                else if (e && FLUSH)
                    emit = 1'b1;
                if (emit) begin
                    m_data = '0;
                    for (int i = 0; i < int'(PPW); i++) begin
                        if (i < cur_q.size())
                            m_data = m_data | (DATA_WIDTH'(cur_q[i]) << (PIX_WIDTH * i));
                        else
                            m_data = m_data | (DATA_WIDTH'(PAD) << (PIX_WIDTH * i));
                    end
                    cur_q.delete();
                    m_cnt++;
                    e_wr = 1'b0;
                    if (m_cnt == int'(CAP)) begin
                        e_fd   = 1'b1;
                        m_full = 1'b1;
                    end
                end
                if (e) begin
                    e_fd     = 1'b1;
                    m_active = 1'b0;
                    m_full   = 1'b0;
                    cur_q.delete();
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare all outputs just after the edge.
    task automatic cyc(input bit pv, input logic [PIX_WIDTH-1:0] px, input bit s, input bit e);
        pix_valid = pv;
        pix_data  = px;
        sof       = s;
        eof       = e;
        model_step(pv, px, s, e);
        @(posedge clk);
        #1;
        check("wr_en_out",  64'(wr_en_out),  64'(e_wr));
        check("frame_done", 64'(frame_done), 64'(e_fd));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("word_cnt",   64'(word_cnt),   64'(m_cnt));
        check("data_out",   64'(data_out),   64'(m_data));
        if (wr_en_out === 1'b0) wr_seen++;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    initial begin
        reset     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        sof       = 1'b0;
        eof       = 1'b0;
        model_reset();
        #12;
        check("rst_wr_en",  64'(wr_en_out),  64'd1);
        check("rst_data",   64'(data_out),   64'd0);
        check("rst_fd",     64'(frame_done), 64'd0);
        check("rst_ovf",    64'(overflow),   64'd0);
        check("rst_cnt",    64'(word_cnt),   64'd0);
        reset = 1'b1;

        // Basic pack
        cyc(1, 8'h11, 1, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);
        check("basic_wr",   64'(wr_en_out), 64'd0);
        check("basic_data", 64'(data_out),  64'h44332211);
        check("basic_cnt",  64'(word_cnt),  64'd1);
        cyc(0, 8'h00, 0, 0);

        // Full frame of exactly capacity, eof on the last pixel
        wr_seen = 0;
        fd_seen = 0;
        for (int i = 0; i < 32; i++)
            cyc(1, 8'(i), i == 0, i == 31);
        check("full_writes", 64'(wr_seen),    64'd8);
        check("full_fd",     64'(fd_seen),    64'd1);
        check("full_last",   64'(data_out),   64'h1F1E1D1C);
        check("full_ovf",    64'(overflow),   64'd0);
        cyc(1, 8'h55, 0, 0);
        check("idle_ignore", 64'(wr_en_out),  64'd1);

        // Overflow: 36 pixels into an 8-word buffer
        wr_seen = 0;
        fd_seen = 0;
        for (int i = 0; i < 36; i++) begin
            cyc(1, 8'(i + 8'h40), i == 0, i == 35);
            if (i == 31) check("ovf_before", 64'(overflow), 64'd0);
            if (i == 32) check("ovf_after",  64'(overflow), 64'd1);
        end
        check("ovf_writes", 64'(wr_seen), 64'd8);
        check("ovf_fd",     64'(fd_seen), 64'd1);
        cyc(1, 8'h99, 1, 0);
        check("ovf_clear",  64'(overflow), 64'd0);
        cyc(1, 8'h9A, 0, 1);

        // Partial eof
        wr_seen = 0;
        fd_seen = 0;
        cyc(1, 8'hAA, 1, 0);
        cyc(1, 8'hBB, 0, 1);
        check("partial_fd",     64'(fd_seen), 64'd1);
        check("partial_writes", 64'(wr_seen), FLUSH ? 64'd1 : 64'd0);
        if (FLUSH) check("partial_data", 64'(data_out), 64'h0000BBAA);

        // Restart with gaps
        wr_seen = 0;
        cyc(1, 8'h01, 1, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(1, 8'h05, 1, 0);
        cyc(1, 8'h06, 0, 0);
        cyc(1, 8'h07, 0, 0);
        cyc(1, 8'h08, 0, 1);
        check("restart_writes", 64'(wr_seen),  64'd1);
        check("restart_data",   64'(data_out), 64'h08070605);

        // Single-pixel frame
        wr_seen = 0;
        cyc(1, 8'h3C, 1, 1);
        check("single_writes", 64'(wr_seen), FLUSH ? 64'd1 : 64'd0);

        // Async reset mid-word while a write is on the bus
        cyc(1, 8'hC1, 1, 0);
        cyc(1, 8'hC2, 0, 0);
        cyc(1, 8'hC3, 0, 0);
        cyc(1, 8'hC4, 0, 0);
        pix_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_wr_en", 64'(wr_en_out), 64'd1);
        check("arst_cnt",   64'(word_cnt),  64'd0);
        check("arst_data",  64'(data_out),  64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 8'hD1, 1, 0);
        cyc(1, 8'hD2, 0, 0);
        cyc(1, 8'hD3, 0, 0);
        cyc(1, 8'hD4, 0, 1);
        check("arst_repack", 64'(data_out), 64'hD4D3D2D1);

        // Randomised frames
        for (int n = 0; n < 4000; n++) begin
            bit pv;
            bit s;
            bit e;
            pv = ($urandom_range(0, 9) < 7);
            s  = pv && ($urandom_range(0, m_active ? 59 : 4) == 0);
            e  = pv && ($urandom_range(0, 29) == 0);
            cyc(pv, 8'($urandom), s, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
